// File: rtl/src_buf_pkg.sv
// Shared constants and writer state encoding for the input ping-pong buffer.
package src_buf_pkg;
    localparam int DATA_W    = 64;
    localparam int ITEM_W    = 32;
    localparam int DEPTH     = 32;
    localparam int AW        = $clog2(DEPTH);
    localparam int LEN_W     = AW + 1;
    localparam int NUM_BANKS = 2;

    typedef enum logic {
        W_FILL = 1'b0,
        W_WAIT = 1'b1
    } wr_state_e;
endpackage

// File: rtl/src_buf_if.sv
// Stream-in and core-side read/release signals of the input ping-pong buffer.
interface src_buf_if;
    import src_buf_pkg::*;

    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tlast;
    logic              bank_ready;
    logic [LEN_W-1:0]  bank_len;
    logic              rd_req;
    logic [LEN_W-1:0]  rd_addr;
    logic              rd_valid;
    logic [ITEM_W-1:0] rd_data;
    logic              bank_release;

    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_tlast, rd_req, rd_addr, bank_release,
        input  s_axis_tready, bank_ready, bank_len, rd_valid, rd_data
    );

    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, rd_req, rd_addr, bank_release,
        output s_axis_tready, bank_ready, bank_len, rd_valid, rd_data
    );
endinterface

// File: rtl/src_buf_bank_ram.sv
// Simple dual-port block RAM, one write port and one registered read port.
module bank_ram #(
    parameter int AW = 5,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    (* ram_style = "block" *) logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
        if (i_re)
            r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/src_buf.sv
// Input ping-pong buffer: DMA fills one bank while the core reads items from the other.
module src_buf
    import src_buf_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    src_buf_if.slave  bus
);
    logic [NUM_BANKS-1:0]             r_full;
    logic [NUM_BANKS-1:0][LEN_W-1:0]  r_len;
    logic                             r_wr_sel;
    logic                             r_rd_sel;
    logic [AW-1:0]                    r_wr_cnt;
    logic                             r_rd_valid;
    logic                             r_rd_bank;
    logic                             r_rd_half;
    wr_state_e                        r_state;
    wr_state_e                        w_state_nxt;

    logic                             w_tready;
    logic                             w_acc;
    logic                             w_close;
    logic                             w_rel;
    logic                             w_rd_go;
    logic [NUM_BANKS-1:0]             w_full_nxt;
    logic [NUM_BANKS-1:0][DATA_W-1:0] w_q;
    logic [ITEM_W-1:0]                w_item;

    assign w_acc   = bus.s_axis_tvalid && w_tready;
    assign w_close = w_acc && (bus.s_axis_tlast || r_wr_cnt == AW'(DEPTH - 1));
    assign w_rel   = bus.bank_release && r_full[r_rd_sel];
    assign w_rd_go = bus.rd_req && r_full[r_rd_sel];

    // Closing and releasing always target different banks, so both may land together.
    always_comb begin
        w_full_nxt = r_full;
        if (w_close)
            w_full_nxt[r_wr_sel] = 1'b1;
        if (w_rel)
            w_full_nxt[r_rd_sel] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= W_FILL;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            W_FILL:  if (w_close && w_full_nxt[~r_wr_sel]) w_state_nxt = W_WAIT;
            W_WAIT:  if (!w_full_nxt[r_wr_sel])            w_state_nxt = W_FILL;
            default: w_state_nxt = W_FILL;
        endcase
    end

    // tready is derived from the bank flags so it rises the cycle after a release.
    always_comb begin
        w_tready = 1'b0;
        if (!rst)
            w_tready = !r_full[r_wr_sel];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full     <= '0;
            r_len      <= '0;
            r_wr_sel   <= 1'b0;
            r_rd_sel   <= 1'b0;
            r_wr_cnt   <= '0;
            r_rd_valid <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_rd_half  <= 1'b0;
        end else begin
            r_full     <= w_full_nxt;
            r_rd_valid <= w_rd_go;
            if (w_acc)
                r_wr_cnt <= w_close ? '0 : r_wr_cnt + AW'(1);
            if (w_close) begin
                r_len[r_wr_sel] <= {1'b0, r_wr_cnt} + LEN_W'(1);
                r_wr_sel        <= ~r_wr_sel;
            end
            if (w_rel)
                r_rd_sel <= ~r_rd_sel;
            if (w_rd_go) begin
                r_rd_bank <= r_rd_sel;
                r_rd_half <= bus.rd_addr[0];
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        bank_ram #(.AW(AW), .DW(DATA_W)) u_ram (
            .clk     (clk),
            .i_we    (w_acc && r_wr_sel == 1'(b)),
            .i_waddr (r_wr_cnt),
            .i_wdata (bus.s_axis_tdata),
            .i_re    (w_rd_go && r_rd_sel == 1'(b)),
            .i_raddr (bus.rd_addr[LEN_W-1:1]),
            .o_rdata (w_q[b])
        );
    end

    assign w_item            = w_q[r_rd_bank][r_rd_half*ITEM_W +: ITEM_W];
    assign bus.s_axis_tready = w_tready;
    assign bus.bank_ready    = r_full[r_rd_sel];
    assign bus.bank_len      = r_len[r_rd_sel];
    assign bus.rd_valid      = r_rd_valid;
    assign bus.rd_data       = r_rd_valid ? w_item : '0;
endmodule
